mpu_alu_seq: RTL and testbench

Sequencer that drives the combinational mpu_alu from instruction words. It accepts one 32-bit instruction over a valid/ready handshake and fetches operands from an internal 8 x 64-bit register file. It presents operands and selectors to the ALU, captures res/flags, optionally writes the result back, and returns res/flags to the issuer over a second valid/ready handshake. It sits between the MPU instruction source and mpu_alu.

---
 rtl/mpu_alu_seq.sv | 124 ++++++++++++
 tb/tb_mpu_alu_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_alu_seq.sv
// Instruction sequencer for mpu_alu: fetches operands from an 8x64 register file,
// drives the ALU, captures res/flags, optionally writes back and returns the result.
module mpu_alu_seq #(
  parameter int CNT_W = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_insn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_res,
  output logic [7:0]       out_flags,
  input  logic             ld_we,
  input  logic [2:0]       ld_addr,
  input  logic [63:0]      ld_data,
  output logic             ld_busy,
  output logic [1:0]       alu_size,
  output logic [3:0]       alu_op,
  output logic [63:0]      alu_o0,
  output logic [63:0]      alu_o1,
  output logic [63:0]      alu_o2,
  output logic [2:0]       alu_s0,
  output logic [2:0]       alu_s1,
  output logic [2:0]       alu_s2,
  output logic [2:0]       alu_sres,
  input  logic [63:0]      alu_res,
  input  logic [7:0]       alu_flags,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_RESP} state_t;

  state_t      r_state;
  logic [30:0] r_insn;
  logic [63:0] r_regs [8];

  logic [3:0] w_op;
  logic [1:0] w_size;
  logic [2:0] w_s0, w_s1, w_s2, w_sres, w_r0, w_r1, w_r2, w_rd;
  logic       w_wb;
  logic       w_unused_rsvd;

  assign w_op          = r_insn[3:0];
  assign w_size        = r_insn[5:4];
  assign w_s0          = r_insn[8:6];
  assign w_s1          = r_insn[11:9];
  assign w_s2          = r_insn[14:12];
  assign w_sres        = r_insn[17:15];
  assign w_r0          = r_insn[20:18];
  assign w_r1          = r_insn[23:21];
  assign w_r2          = r_insn[26:24];
  assign w_rd          = r_insn[29:27];
  assign w_wb          = r_insn[30];
  assign w_unused_rsvd = in_insn[31];

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_RESP);
  assign ld_busy   = ld_we & (r_state != S_IDLE);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state   <= S_IDLE;
      r_insn    <= '0;
      out_res   <= '0;
      out_flags <= '0;
      alu_size  <= '0;
      alu_op    <= '0;
      alu_o0    <= '0;
      alu_o1    <= '0;
      alu_o2    <= '0;
      alu_s0    <= '0;
      alu_s1    <= '0;
      alu_s2    <= '0;
      alu_sres  <= '0;
      retired   <= '0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Host write lands this edge, so an instruction accepted now sees it in READ.
          if (ld_we) r_regs[ld_addr] <= ld_data;
          if (in_valid) begin
            r_insn  <= in_insn[30:0];
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (w_op == 4'd0) begin
            out_res   <= '0;
            out_flags <= '0;
            r_state   <= S_RESP;
          end else begin
            alu_o0   <= r_regs[w_r0];
            alu_o1   <= r_regs[w_r1];
            alu_o2   <= r_regs[w_r2];
            alu_size <= w_size;
            alu_op   <= w_op;
            alu_s0   <= w_s0;
            alu_s1   <= w_s1;
            alu_s2   <= w_s2;
            alu_sres <= w_sres;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          out_res   <= alu_res;
          out_flags <= alu_flags;
          if (w_wb) r_regs[w_rd] <= alu_res;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          if (out_ready) begin
            retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_alu_seq.sv
// Directed bench for mpu_alu_seq with a stub ALU (res = o0^o1^o2, flags = {op, 4'hA}).
module tb_mpu_alu_seq;
  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_insn;
  logic [63:0] out_res;
  logic [7:0]  out_flags;
  logic        ld_we, ld_busy;
  logic [2:0]  ld_addr;
  logic [63:0] ld_data;
  logic [1:0]  alu_size;
  logic [3:0]  alu_op;
  logic [63:0] alu_o0, alu_o1, alu_o2, alu_res;
  logic [2:0]  alu_s0, alu_s1, alu_s2, alu_sres;
  logic [7:0]  alu_flags;
  logic [3:0]  retired;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_retired = '0;

  always #5 sys_clk = ~sys_clk;

  assign alu_res   = alu_o0 ^ alu_o1 ^ alu_o2;
  assign alu_flags = {alu_op, 4'hA};

  mpu_alu_seq #(.CNT_W(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_flags(out_flags),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .ld_busy(ld_busy),
    .alu_size(alu_size), .alu_op(alu_op),
    .alu_o0(alu_o0), .alu_o1(alu_o1), .alu_o2(alu_o2),
    .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_s2(alu_s2), .alu_sres(alu_sres),
    .alu_res(alu_res), .alu_flags(alu_flags), .retired(retired)
  );

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [1:0] sz,
                                     input logic [2:0] s0, input logic [2:0] s1,
                                     input logic [2:0] s2, input logic [2:0] sr,
                                     input logic [2:0] r0, input logic [2:0] r1,
                                     input logic [2:0] r2, input logic [2:0] rd,
                                     input logic wb);
    mk = {1'b0, wb, rd, r2, r1, r0, sr, s2, s1, s0, sz, op};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [63:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  // Present an instruction for exactly one edge (the accept edge).
  task automatic issue(input logic [31:0] insn);
    in_valid = 1'b1; in_insn = insn;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic finish_resp();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_retired = exp_retired + 4'd1;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (retired !== 4'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    checks++; if ({out_res, out_flags, alu_o0, alu_op} !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", {out_res, out_flags, alu_o0, alu_op}); end
  endtask

  task automatic test_basic();
    logic [11:0] sel_exp;
    sel_exp = {3'd0, 3'd1, 3'd2, 3'd3};
    load(3'd0, 64'h55);
    load(3'd1, 64'hAA00);
    load(3'd2, 64'h550000);
    checks++; if (ld_busy !== 1'b0) begin failures++; $display("FAIL idle_ld_busy got=%b exp=0", ld_busy); end
    issue(mk(4'd1, 2'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd7, 1'b0));
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready_read got=%b exp=0", in_ready); end
    tick();
    checks++; if ({alu_s0, alu_s1, alu_s2, alu_sres} !== sel_exp) begin failures++; $display("FAIL basic_selectors got=%h exp=%h", {alu_s0, alu_s1, alu_s2, alu_sres}, sel_exp); end
    checks++; if (alu_o1 !== 64'hAA00) begin failures++; $display("FAIL basic_alu_o1 got=%h exp=aa00", alu_o1); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_res !== 64'h55AA55) begin failures++; $display("FAIL basic_out_res got=%h exp=55aa55", out_res); end
    checks++; if (out_flags !== 8'h1A) begin failures++; $display("FAIL basic_out_flags got=%h exp=1a", out_flags); end
    finish_resp();
    checks++; if (retired !== exp_retired) begin failures++; $display("FAIL basic_retired got=%0d exp=%0d", retired, exp_retired); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL basic_return_idle got=%b%b exp=01", out_valid, in_ready); end
  endtask

  task automatic test_writeback();
    issue(mk(4'd2, 2'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 1'b1));
    tick();
    checks++; if (alu_size !== 2'd1) begin failures++; $display("FAIL wb_alu_size got=%0d exp=1", alu_size); end
    tick();
    checks++; if (out_res !== 64'h55AA55) begin failures++; $display("FAIL wb_first_res got=%h exp=55aa55", out_res); end
    finish_resp();
    issue(mk(4'd2, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd4, 3'd4, 3'd0, 1'b0));
    tick(); tick();
    checks++; if (out_res !== 64'h55AA55) begin failures++; $display("FAIL wb_chain_res got=%h exp=55aa55", out_res); end
    checks++; if (out_flags !== 8'h2A) begin failures++; $display("FAIL wb_chain_flags got=%h exp=2a", out_flags); end
    finish_resp();
  endtask

  task automatic test_backpressure();
    issue(mk(4'd1, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd0, 1'b0));
    tick(); tick();
    in_valid = 1'b1;
    in_insn  = mk(4'd7, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_%0d got valid=%b ready=%b exp valid=1 ready=0", i, out_valid, in_ready); end
      checks++; if (out_res !== 64'h55AA55) begin failures++; $display("FAIL bp_res_stable_%0d got=%h exp=55aa55", i, out_res); end
      tick();
    end
    in_valid = 1'b0;
    finish_resp();
    checks++; if (retired !== exp_retired) begin failures++; $display("FAIL bp_retired got=%0d exp=%0d", retired, exp_retired); end
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_accept got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid); end
  endtask

  task automatic test_ld_busy();
    issue(mk(4'd3, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd0, 1'b0));
    tick();
    ld_we = 1'b1; ld_addr = 3'd5; ld_data = 64'hFFFF;
    #1;
    checks++; if (ld_busy !== 1'b1) begin failures++; $display("FAIL ld_busy_exec got=%b exp=1", ld_busy); end
    tick();
    ld_we = 1'b0;
    finish_resp();
    issue(mk(4'd3, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 3'd5, 3'd5, 3'd0, 1'b0));
    tick(); tick();
    checks++; if (out_res !== 64'h0) begin failures++; $display("FAIL ld_dropped_res got=%h exp=0", out_res); end
    checks++; if (out_flags !== 8'h3A) begin failures++; $display("FAIL ld_dropped_flags got=%h exp=3a", out_flags); end
    finish_resp();
    // Host write in the same cycle as accept must reach that instruction's READ.
    ld_we = 1'b1; ld_addr = 3'd6; ld_data = 64'h1234;
    issue(mk(4'd4, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd6, 3'd6, 3'd0, 1'b0));
    ld_we = 1'b0;
    tick(); tick();
    checks++; if (out_res !== 64'h1234) begin failures++; $display("FAIL ld_same_cycle_res got=%h exp=1234", out_res); end
    finish_resp();
  endtask

  task automatic test_nop();
    logic [3:0] start_ret;
    issue(mk(4'd0, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd0, 1'b1));
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL nop_early_valid got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL nop_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_res !== 64'h0 || out_flags !== 8'h0) begin failures++; $display("FAIL nop_result got=%h/%h exp=0/0", out_res, out_flags); end
    checks++; if (alu_op !== 4'd4 || alu_o0 !== 64'h1234) begin failures++; $display("FAIL nop_alu_held got op=%0d o0=%h exp op=4 o0=1234", alu_op, alu_o0); end
    finish_resp();
    issue(mk(4'd5, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd4, 3'd0, 1'b0));
    tick(); tick();
    checks++; if (out_res !== 64'h55 || out_flags !== 8'h5A) begin failures++; $display("FAIL nop_reg0_kept got=%h/%h exp=55/5a", out_res, out_flags); end
    finish_resp();
    start_ret = exp_retired;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      issue(mk(4'd0, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0));
      tick();
      tick();
      exp_retired = exp_retired + 4'd1;
    end
    out_ready = 1'b0;
    checks++; if (retired !== exp_retired || exp_retired !== start_ret) begin failures++; $display("FAIL nop_wrap got=%0d exp=%0d", retired, start_ret); end
  endtask

  task automatic test_reset_mid();
    load(3'd0, 64'h1234);
    issue(mk(4'd1, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd6, 1'b1));
    tick();
    sys_rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_handshake got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid); end
    checks++; if (retired !== 4'd0 || alu_o0 !== 64'h0) begin failures++; $display("FAIL rst_mid_state got ret=%0d o0=%h exp 0/0", retired, alu_o0); end
    tick();
    sys_rst = 1'b0;
    exp_retired = '0;
    tick();
    issue(mk(4'd1, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd6, 3'd6, 3'd0, 1'b0));
    tick(); tick();
    checks++; if (out_res !== 64'h0) begin failures++; $display("FAIL rst_mid_no_wb got=%h exp=0", out_res); end
    finish_resp();
    checks++; if (retired !== exp_retired) begin failures++; $display("FAIL rst_mid_retired got=%0d exp=%0d", retired, exp_retired); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    sys_rst = 1'b1; in_valid = 1'b0; in_insn = '0; out_ready = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    tick(); tick();
    test_reset();
    sys_rst = 1'b0;
    tick();
    test_basic();
    test_writeback();
    test_backpressure();
    test_ld_busy();
    test_nop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
